// File: rtl/registro_universal.sv
// registro_universal: N-bit universal shift register with burst serialiser (optional REGISTRO_PARITY_EN appends an even-parity bit)
module registro_universal #(
  parameter int           N       = 4,
  parameter logic [N-1:0] RST_VAL = '0
) (
  input  logic         CLK,
  input  logic         RST_L,
  input  logic         ENB,
  input  logic [2:0]   MODO,
  input  logic         DIR,
  input  logic         S_IN,
  input  logic [N-1:0] D,
  output logic [N-1:0] Q,
  output logic [N-1:0] Qn,
  output logic         S_OUT,
  output logic         BUSY,
  output logic         DONE
);
`ifdef REGISTRO_PARITY_EN
  localparam int L = N + 1;
`else
  localparam int L = N;
`endif
  localparam int CW = $clog2(L + 1);
  typedef enum logic {IDLE, SHIFTING} state_t;
  state_t       state_q, state_d;
  logic [N-1:0] q_q, q_d;
  logic         s_out_q, s_out_d;
  logic         done_q, done_d;
  logic         dir_q, dir_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0] burst_q;
  logic         burst_s;
`ifdef REGISTRO_PARITY_EN
  logic         par_q, par_d;
`endif
  assign burst_q = dir_q ? {1'b0, q_q[N-1:1]} : {q_q[N-2:0], 1'b0};
  assign burst_s = dir_q ? q_q[0] : q_q[N-1];
  // next state: burst shifting owns the register while busy, otherwise decode MODO
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    s_out_d = s_out_q;
    done_d  = 1'b0;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
`ifdef REGISTRO_PARITY_EN
    par_d   = par_q;
`endif
    if (ENB) begin
      if (state_q == SHIFTING) begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
`ifdef REGISTRO_PARITY_EN
        // last edge emits the parity bit; the data is already fully shifted out
        if (cnt_q == CW'(1)) s_out_d = par_q;
        else begin
          q_d     = burst_q;
          s_out_d = burst_s;
        end
`else
        q_d     = burst_q;
        s_out_d = burst_s;
`endif
      end else begin
        case (MODO)
          3'b001: begin
            q_d     = DIR ? {S_IN, q_q[N-1:1]} : {q_q[N-2:0], S_IN};
            s_out_d = DIR ? q_q[0] : q_q[N-1];
          end
          3'b010: begin
            q_d     = DIR ? {q_q[0], q_q[N-1:1]} : {q_q[N-2:0], q_q[N-1]};
            s_out_d = DIR ? q_q[0] : q_q[N-1];
          end
          3'b011: q_d = D;
          3'b100: begin
            q_d     = D;
            dir_d   = DIR;
            cnt_d   = CW'(L);
            state_d = SHIFTING;
`ifdef REGISTRO_PARITY_EN
            par_d   = ^D;
`endif
          end
          3'b101: begin
            q_d     = {q_q[N-1], q_q[N-1:1]};
            s_out_d = q_q[0];
          end
          3'b110: q_d = q_q + 1'b1;
          3'b111: q_d = q_q - 1'b1;
          default: q_d = q_q;
        endcase
      end
    end
  end
  // state registers; async reset aborts any burst without a DONE
  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      state_q <= IDLE;
      q_q     <= RST_VAL;
      s_out_q <= 1'b0;
      done_q  <= 1'b0;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef REGISTRO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      s_out_q <= s_out_d;
      done_q  <= done_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
`ifdef REGISTRO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end
  assign Q     = q_q;
  assign Qn    = ~q_q;
  assign S_OUT = s_out_q;
  assign BUSY  = (state_q == SHIFTING);
  assign DONE  = done_q;
endmodule

// File: tb/tb_registro_universal.sv
// tb_registro_universal: directed bench with a queue-based reference model of registro_universal
module tb_registro_universal;
`ifdef REGISTRO_PARITY_EN
  localparam int L = 5;
`else
  localparam int L = 4;
`endif
  logic       clk = 0, rst_l = 1, en = 0, dir = 0, s_in = 0;
  logic [2:0] modo = 0;
  logic [3:0] d = 0;
  logic [3:0] q, qn;
  logic       s_out, busy, done;
  int         tests = 0, fails = 0;
  bit         check_en = 0;
  int         m_q = 0, m_left = 0;
  bit         m_s = 0, m_busy = 0, m_done = 0, m_dir = 0;
  bit         bq[$];

  registro_universal #(.N(4), .RST_VAL(4'hA)) dut (
    .CLK(clk), .RST_L(rst_l), .ENB(en), .MODO(modo), .DIR(dir), .S_IN(s_in), .D(d),
    .Q(q), .Qn(qn), .S_OUT(s_out), .BUSY(busy), .DONE(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: plain arithmetic on an integer, burst as a queue of outgoing bits
  always @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      m_q = 10; m_s = 0; m_busy = 0; m_done = 0; m_dir = 0; m_left = 0;
      bq.delete();
    end else begin
      m_done = 0;
      if (en && m_busy) begin
        m_s = bq.pop_front();
        if (m_left > 0) begin
          m_q = m_dir ? m_q / 2 : (m_q * 2) % 16;
          m_left--;
        end
        if (bq.size() == 0) begin
          m_busy = 0;
          m_done = 1;
        end
      end else if (en) begin
        case (modo)
          3'd1: begin
            m_s = dir ? bit'(m_q % 2) : bit'(m_q / 8);
            m_q = dir ? m_q / 2 + 8 * int'(s_in) : (m_q * 2 + int'(s_in)) % 16;
          end
          3'd2: begin
            m_s = dir ? bit'(m_q % 2) : bit'(m_q / 8);
            m_q = dir ? m_q / 2 + 8 * (m_q % 2) : (m_q * 2) % 16 + m_q / 8;
          end
          3'd3: m_q = int'(d);
          3'd4: begin
            for (int i = 0; i < 4; i++) bq.push_back(dir ? d[i] : d[3-i]);
`ifdef REGISTRO_PARITY_EN
            bq.push_back(bit'($countones(d) % 2));
`endif
            m_q = int'(d); m_busy = 1; m_left = 4; m_dir = dir;
          end
          3'd5: begin
            m_s = bit'(m_q % 2);
            m_q = m_q / 2 + (m_q >= 8 ? 8 : 0);
          end
          3'd6: m_q = (m_q + 1) % 16;
          3'd7: m_q = (m_q + 15) % 16;
          default: ;
        endcase
      end
    end
  end

  // every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (check_en) begin
      chk("model_q", int'(q), m_q);
      chk("model_qn", int'(qn), 15 - m_q);
      chk("model_sout", int'(s_out), int'(m_s));
      chk("model_busy", int'(busy), int'(m_busy));
      chk("model_done", int'(done), int'(m_done));
    end
  end

  task automatic step(input logic e, input logic [2:0] m, input logic dr, input logic si, input logic [3:0] dv);
    en = e; modo = m; dir = dr; s_in = si; d = dv;
    @(posedge clk);
    #2;
  endtask

  task automatic async_reset();
    rst_l = 0;
    #1;
    chk("rst_q", int'(q), 4'b1010);
    chk("rst_qn", int'(qn), 4'b0101);
    chk("rst_sout", int'(s_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    @(negedge clk);
    #1;
    rst_l = 1;
  endtask

  // burst with the mode/data inputs scrambled each cycle to show they are ignored
  task automatic burst(input logic dr, input logic [3:0] dv, input logic [4:0] exp);
    int ndone = 0;
    step(1, 3'b100, dr, 0, dv);
    chk("burst_load_q", int'(q), int'(dv));
    chk("burst_load_busy", int'(busy), 1);
    for (int i = 0; i < L; i++) begin
      step(1, 3'(i % 2 ? 3'b011 : 3'b110), ~dr, 1, 4'hF);
      chk("burst_sout", int'(s_out), int'(exp[L-1-i]));
      chk("burst_busy", int'(busy), int'(i < L - 1));
      ndone += int'(done);
    end
    chk("burst_done_count", ndone, 1);
    chk("burst_end_q", int'(q), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk);
    #2;
    async_reset();
    check_en = 1;
    step(1, 3'b011, 0, 0, 4'b1011);
    chk("load_q", int'(q), 4'b1011);
    step(1, 3'b001, 0, 1, 4'h0);
    chk("shl_q", int'(q), 4'b0111);
    chk("shl_sout", int'(s_out), 1);
    step(1, 3'b010, 1, 0, 4'h0);
    chk("rotr_q", int'(q), 4'b1011);
    chk("rotr_sout", int'(s_out), 1);
    step(1, 3'b101, 0, 0, 4'h0);
    chk("asr_q", int'(q), 4'b1101);
    chk("asr_sout", int'(s_out), 1);
    step(1, 3'b010, 0, 0, 4'h0);
    chk("rotl_q", int'(q), 4'b1011);
    step(1, 3'b001, 1, 0, 4'h0);
    chk("shr_q", int'(q), 4'b0101);
    step(0, 3'b110, 0, 0, 4'h0);
    chk("enb_hold_q", int'(q), 4'b0101);
    step(1, 3'b011, 0, 0, 4'b1110);
    step(1, 3'b110, 0, 0, 4'h0);
    chk("up_q", int'(q), 4'b1111);
    step(1, 3'b110, 0, 0, 4'h0);
    chk("up_wrap_q", int'(q), 4'b0000);
    step(1, 3'b111, 0, 0, 4'h0);
    chk("down_wrap_q", int'(q), 4'b1111);
    step(1, 3'b000, 0, 1, 4'h3);
    chk("hold_q", int'(q), 4'b1111);
`ifdef REGISTRO_PARITY_EN
    burst(1, 4'b1101, 5'b10111);
    burst(0, 4'b1101, 5'b11011);
`else
    burst(1, 4'b1101, 5'b01011);
    burst(0, 4'b1101, 5'b01101);
`endif
    step(1, 3'b000, 0, 0, 4'h0);
    chk("post_burst_done", int'(done), 0);
    // burst paused by ENB for two cycles
    step(1, 3'b100, 1, 0, 4'b1101);
    step(1, 3'b000, 0, 0, 4'h0);
    chk("pause_s1", int'(s_out), 1);
    step(1, 3'b000, 0, 0, 4'h0);
    chk("pause_s2", int'(s_out), 0);
    step(0, 3'b011, 0, 0, 4'hF);
    step(0, 3'b011, 0, 0, 4'hF);
    chk("pause_hold_busy", int'(busy), 1);
    chk("pause_hold_q", int'(q), 4'b0011);
    for (int i = 2; i < L; i++) step(1, 3'b000, 0, 0, 4'h0);
    chk("pause_done", int'(done), 1);
    step(1, 3'b000, 0, 0, 4'h0);
    chk("pause_done_pulse", int'(done), 0);
    // reset in the middle of a burst
    step(1, 3'b100, 1, 0, 4'b1101);
    step(1, 3'b000, 0, 0, 4'h0);
    step(1, 3'b000, 0, 0, 4'h0);
    async_reset();
    for (int i = 0; i < 4; i++) begin
      step(1, 3'b000, 0, 0, 4'h0);
      chk("abort_no_done", int'(done), 0);
    end
    chk("abort_q", int'(q), 4'b1010);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/registro_universal.md
Name: registro_universal

Overview:
- Parametrised N-bit universal shift register; next generation of the 4-bit structural/conditional registers.
- Adds: generic width, 3-bit mode, arithmetic shift, up/down counting, and an autonomous burst-serialise mode with BUSY/DONE handshake.
- Used as a parallel-to-serial front end and general-purpose register in datapaths; drop-in for the 4-bit parts when N=4 and MODO[2]=0.

Parameters:
- N, 4, register width in bits (N >= 2).
- RST_VAL, 0, value loaded into Q on reset (N bits).

Ports:
- CLK  in  1  clock; all state changes on rising edge.
- RST_L  in  1  asynchronous, active-low reset.
- ENB  in  1  synchronous enable; low = hold all state, burst paused.
- MODO  in  3  operation mode, sampled each enabled edge when not BUSY.
- DIR  in  1  shift direction: 0 = toward MSB (left), 1 = toward LSB (right).
- S_IN  in  1  serial fill bit for plain shift.
- D  in  N  parallel data.
- Q  out  N  register contents.
- Qn  out  N  bitwise complement of Q, combinational.
- S_OUT  out  1  registered; last bit shifted or rotated out.
- BUSY  out  1  high while a burst is in progress.
- DONE  out  1  one-cycle pulse at burst completion.

Behaviour:
- Reset (RST_L=0, async): Q=RST_VAL, S_OUT=0, BUSY=0, DONE=0, burst counter=0, latched direction=0. Reset mid-burst aborts it; no DONE is produced.
- ENB=0: Q, S_OUT, BUSY and counter hold. DONE is forced to 0 on that edge.
- DONE defaults to 0 every enabled edge unless set by burst completion.
- Modes, applied when ENB=1 and BUSY=0:
  - 000 hold.
  - 001 shift:
    - DIR=0: Q<={Q[N-2:0],S_IN}, S_OUT<=Q[N-1].
    - DIR=1: Q<={S_IN,Q[N-1:1]}, S_OUT<=Q[0].
  - 010 rotate:
    - DIR=0: Q<={Q[N-2:0],Q[N-1]}, S_OUT<=Q[N-1].
    - DIR=1: Q<={Q[0],Q[N-1:1]}, S_OUT<=Q[0].
  - 011 parallel load: Q<=D; S_OUT holds.
  - 100 burst start: Q<=D, latch DIR, counter<=L (L=N, or N+1 with the optional feature), BUSY<=1; S_OUT holds.
  - 101 arithmetic shift right: Q<={Q[N-1],Q[N-1:1]}, S_OUT<=Q[0]; DIR is ignored.
  - 110 count up: Q<=Q+1 modulo 2^N (all-ones wraps to 0); S_OUT holds.
  - 111 count down: Q<=Q-1 modulo 2^N (0 wraps to all-ones); S_OUT holds.
- Burst state machine, IDLE -> SHIFTING -> IDLE:
  - While BUSY=1, MODO, D, DIR and S_IN are ignored.
  - Each enabled edge shifts once in the latched direction with 0 fill; S_OUT gets the leaving bit; counter decrements.
  - On the edge where the counter goes 1->0: BUSY<=0 and DONE<=1 for exactly one cycle.
  - Start-to-DONE latency is L+1 enabled edges (one load edge plus L shift edges).
  - A new MODO command is accepted on the edge after DONE rises; back-to-back bursts are allowed with no idle cycle.
  - After a burst without the optional feature, Q=0.

Optional Feature:
- Macro: REGISTRO_PARITY_EN.
- Defined:
  - Burst length L=N+1.
  - Even parity (XOR of the loaded D) is captured at burst start.
  - After the N data bits, the final shift edge drives S_OUT<=parity; Q stays 0 on that edge.
  - DONE follows that edge.
- Undefined: L=N, there is no parity bit, and the parity logic is absent.

Test Plan:
- N=4, RST_VAL=4'hA: assert RST_L low asynchronously mid-cycle -> Q=1010, Qn=0101, S_OUT=0, BUSY=0, DONE=0 immediately, without waiting for a clock edge.
- Load 1011 (011), then shift with DIR=0, S_IN=1 -> Q=0111, S_OUT=1; rotate DIR=1 -> Q=1011, S_OUT=1; ASR -> Q=1101, S_OUT=1.
- Count up from 1110 -> 1111, then 0000 (wrap); count down from 0000 -> 1111.
- Burst D=1101, DIR=1, no macro -> S_OUT sequence 1,0,1,1 on edges 1-4 after load; BUSY high for 4 cycles; DONE one pulse; Q=0000. Changing MODO mid-burst has no effect.
- Same burst with ENB low for 2 cycles mid-burst -> sequence and DONE delayed by exactly 2 cycles, DONE still a single pulse. Reset after 2 shifts -> BUSY=0, no DONE.
- REGISTRO_PARITY_EN, D=1101, DIR=0 -> S_OUT 1,1,0,1, then parity 1; DONE on the 5th shift edge.
